// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// SubBytes and the key schedule live outside this block: the current state is
// presented on sbox_in_o and the round key is requested through rk_idx_o, with
// both answers returned combinationally in the same cycle. A chain register
// provides optional CBC chaining.

package aes_pkg;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the state sits at [127-8n -: 8]; byte n = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

module aes_enc_iter #(
  parameter int KEY_BITS = 128,
  parameter bit CBC_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plain_text_i,
  input  logic         cbc_en_i,
  input  logic         iv_load_i,
  input  logic [127:0] iv_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rnd_key_i,
  output logic [127:0] sbox_in_o,
  input  logic [127:0] mapped_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] cipher_o,
  output logic         busy_o
);
  import aes_pkg::*;

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 :
                              (KEY_BITS == 192) ? 4'd12 : 4'd10;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] cipher_q, cipher_d;
  logic [127:0] chain_q, chain_d;
  logic         out_valid_q, out_valid_d;
  logic         cbc_q, cbc_d;

  logic [127:0] sr_val;
  logic [127:0] final_val;
  logic [127:0] chain_src;

  // Next-state and output decode for the IDLE/ROUND/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    cipher_d    = cipher_q;
    chain_d     = chain_q;
    out_valid_d = out_valid_q;
    cbc_d       = cbc_q;
    in_ready_o  = 1'b0;
    rk_idx_o    = 4'd0;
    sbox_in_o   = '0;
    sr_val      = shift_rows(mapped_i);
    final_val   = sr_val ^ rnd_key_i;
    chain_src   = chain_q;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        // An IV load in the accept cycle takes effect before the XOR.
        if (iv_load_i) begin
          chain_d   = iv_i;
          chain_src = iv_i;
        end
        if (in_valid_i) begin
          cbc_d   = CBC_EN && cbc_en_i;
          st_d    = (plain_text_i ^ (cbc_d ? chain_src : 128'd0)) ^ rnd_key_i;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx_o  = rnd_q;
        sbox_in_o = st_q;
        if (rnd_q == NR) begin
          cipher_d    = final_val;
          out_valid_d = 1'b1;
          state_d     = DONE;
          if (cbc_q) begin
            chain_d = final_val;
          end
        end else begin
          st_d  = mix_columns(sr_val) ^ rnd_key_i;
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight block and clears the chain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      cipher_q    <= '0;
      chain_q     <= '0;
      out_valid_q <= 1'b0;
      cbc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      cipher_q    <= cipher_d;
      chain_q     <= chain_d;
      out_valid_q <= out_valid_d;
      cbc_q       <= cbc_d;
    end
  end

  assign cipher_o    = cipher_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != IDLE);

endmodule
